mips_stage_ex_muldiv: RTL and testbench
=======================================

// Module: mips_stage_ex_muldiv
// PURPOSE
//  Parametrised execute stage: single-cycle ALU plus iterative multiply/divide unit with HI/LO registers.
//  Sits between the register-read pipeline register and EX/MEM.
//  Consumes forwarded operands. Stalls the hazard unit while a mul/div is busy and a dependent op arrives.
//  Next generation of the single-cycle EX stage: adds WIDTH, multi-cycle ops and HI/LO state.
// PARAMETERS
//  WIDTH        32  datapath width; HI/LO each WIDTH bits; must be even, >=8
//  DELAYED      1   1: EX/MEM outputs registered (1-cycle latency); 0: ALU result combinational
//  MUL_LATENCY  4   cycles from MULT accept to HI/LO valid; 1..8
//  DIV_BITS     2   quotient bits retired per cycle; 1, 2 or 4; WIDTH % DIV_BITS == 0
// PORTS
//  ctrl        in   bundle  Data_Control_Control_T; ctrl.clock rising edge; ctrl.reset asynchronous, active-low
//  in_valid    in   1       instruction present in EX
//  in_op       in   5       0-11 ADD SUB AND OR XOR NOR SLT SLTU SLL SRL SRA LUI
//                           12-19 MULT MULTU DIV DIVU MFHI MFLO MTHI MTLO; 20-22 MADD MADDU MSUB
//  in_a, in_b  in   WIDTH   forwarded operands (rs, rt)
//  in_shamt    in   5       shift amount
//  in_dest     in   5       destination register; 0 = none
//  in_pc       in   WIDTH   instruction address, passed through
//  flush       in   1       kill the EX instruction and any in-flight mul/div
//  stall       out  1       hold the upstream pipeline this cycle
//  out_valid   out  1       EX/MEM entry valid
//  out_result  out  WIDTH   ALU, MFHI or MFLO result
//  out_dest    out  5       destination register
//  out_pc      out  WIDTH   passed-through PC
//  out_illegal out  1       opcode not supported in this build
//  busy        out  1       mul/div FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; HI=LO=0; FSM=IDLE; counters=0. Async assert, sync-released state.
//  ALU ops: result visible after 1 cycle (DELAYED=1) or the same cycle (DELAYED=0); never stall.
//  Shifts use in_shamt[4:0] masked to log2(WIDTH). SLT signed, SLTU unsigned. ADD/SUB wrap, no trap.
//  FSM states:
//   IDLE -> MUL on MULT/MULTU(/MADD*); load cnt=MUL_LATENCY-1
//   IDLE -> DIV on DIV/DIVU; load cnt=WIDTH/DIV_BITS-1
//   MUL/DIV -> DONE when cnt==0; DONE writes HI/LO, then -> IDLE the next cycle
//  Mul/div issue: out_valid=1, out_dest=0 (no register write); pipeline proceeds, no stall.
//  stall=1 while busy and in_valid with op in {MULT..MADD*}, {MFHI, MFLO, MTHI, MTLO}.
//  Instruction is held, not consumed. Released the cycle after DONE; MFHI/MFLO then read the new value.
//  MULT: signed WIDTHxWIDTH -> 2*WIDTH; HI=upper, LO=lower. MULTU unsigned.
//  DIV: restoring radix-2^DIV_BITS on magnitudes; LO=quotient, HI=remainder.
//   Quotient truncates toward zero; remainder takes the dividend sign.
//   DIV of -2^(WIDTH-1) by -1: LO=-2^(WIDTH-1), HI=0.
//  Divide by zero: completes in normal latency; LO=all ones, HI=in_a. No exception.
//  MTHI/MTLO (idle): write HI/LO at cycle end; out_dest=0.
//  MFHI/MFLO same cycle as DONE: stalled one cycle (no bypass of the DONE write).
//  flush: drops the EX instruction (out_valid=0 next cycle). In MUL/DIV: abort to IDLE, HI/LO unchanged.
//   Flush in the DONE cycle: HI/LO write still commits.
//  Simultaneous flush and stall: flush wins; stall=0.
//  Reset mid-operation: FSM to IDLE immediately; HI/LO cleared.
// CONFIGURATION
//  MIPS_EX_MADD_EN defined:
//   MADD/MADDU: HI:LO += product. MSUB: HI:LO -= signed product. Same latency as MULT.
//   Accumulate is mod 2^(2*WIDTH).
//  MIPS_EX_MADD_EN undefined:
//   ops 20-22, and any op >22 in every build, give out_illegal=1 for one cycle, out_valid=0.
//   HI/LO untouched, no FSM transition.
// TESTING
//  Reset low mid-DIV -> busy=0, HI=LO=0, out_valid=0 within same cycle; no update after release.
//  ADD 0x7FFFFFFF+1, DELAYED=1 -> next cycle out_result=0x80000000, out_valid=1, stall never high.
//  MULT -3 x 5 then MFLO next cycle -> stall high 4 cycles (MUL_LATENCY=4) then out_result=0xFFFFFFF1;
//   MFHI gives 0xFFFFFFFF.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 16 cycles (DIV_BITS=2); DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
//  DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  MULT issued, flush on cycle 2 -> busy=0 next cycle, HI/LO retain previous values.
//  MADD after HI:LO=0x1_FFFFFFFF, operands 1,1 -> HI=2, LO=0 (MIPS_EX_MADD_EN).
//  Without the macro -> out_illegal=1 one cycle, HI/LO unchanged.

Source files
------------

// File: rtl/mips_stage_ex_muldiv.sv
// MIPS execute stage: single-cycle ALU plus an iterative multiply/divide unit that owns HI/LO.
// Define MIPS_EX_MADD_EN to enable MADD/MADDU/MSUB accumulation into HI:LO.
package mips_ex_pkg;

    typedef struct packed {
        logic clock;
        logic reset;
    } Data_Control_Control_T;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
        OP_XOR   = 5'd4,  OP_NOR   = 5'd5,  OP_SLT   = 5'd6,  OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,  OP_SRL   = 5'd9,  OP_SRA   = 5'd10, OP_LUI   = 5'd11,
        OP_MULT  = 5'd12, OP_MULTU = 5'd13, OP_DIV   = 5'd14, OP_DIVU  = 5'd15,
        OP_MFHI  = 5'd16, OP_MFLO  = 5'd17, OP_MTHI  = 5'd18, OP_MTLO  = 5'd19,
        OP_MADD  = 5'd20, OP_MADDU = 5'd21, OP_MSUB  = 5'd22
    } op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;
    typedef enum logic [1:0] {K_MUL, K_MADD, K_MSUB, K_DIV} md_kind_e;

endpackage

module mips_stage_ex_muldiv
    import mips_ex_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DELAYED     = 1,
    parameter int MUL_LATENCY = 4,
    parameter int DIV_BITS    = 2
) (
    input  Data_Control_Control_T ctrl,
    input  logic                  in_valid,
    input  logic [4:0]            in_op,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [4:0]            in_shamt,
    input  logic [4:0]            in_dest,
    input  logic [WIDTH-1:0]      in_pc,
    input  logic                  flush,
    output logic                  stall,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_result,
    output logic [4:0]            out_dest,
    output logic [WIDTH-1:0]      out_pc,
    output logic                  out_illegal,
    output logic                  busy
);

`ifdef MIPS_EX_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam int SHW   = ($clog2(WIDTH) > 5) ? 5 : $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int HALF  = WIDTH / 2;

    logic clk;
    logic rst_n;
    assign clk   = ctrl.clock;
    assign rst_n = ctrl.reset;

    md_state_e          state_q, state_d;
    md_kind_e           kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

    // ---------------- decode ----------------
    logic is_alu, is_mul, is_div, is_md, legal, issue;

    always_comb begin
        is_alu = (in_op <= 5'd11);
        is_mul = (in_op == OP_MULT) || (in_op == OP_MULTU) ||
                 (MADD_EN && ((in_op == OP_MADD) || (in_op == OP_MADDU) || (in_op == OP_MSUB)));
        is_div = (in_op == OP_DIV) || (in_op == OP_DIVU);
        // Every HI/LO-touching op waits for the unit; ALU ops flow past it.
        is_md  = ((in_op >= 5'd12) && (in_op <= 5'd19)) ||
                 (MADD_EN && (in_op >= 5'd20) && (in_op <= 5'd22));
        legal  = is_alu || is_md;
    end

    assign busy  = (state_q != ST_IDLE);
    assign stall = busy && in_valid && is_md && !flush;
    assign issue = in_valid && !flush && !stall && legal;

    // ---------------- ALU ----------------
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] alu_res;

    assign sh_amt = in_shamt[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_SLL:  alu_res = in_b << sh_amt;
            OP_SRL:  alu_res = in_b >> sh_amt;
            OP_SRA:  alu_res = WIDTH'($signed(in_b) >>> sh_amt);
            OP_LUI:  alu_res = {in_b[HALF-1:0], {HALF{1'b0}}};
            default: alu_res = '0;
        endcase
    end

    // ---------------- multiply operand prep ----------------
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, mul_prod;

    always_comb begin
        mul_signed = (in_op == OP_MULT) || (in_op == OP_MADD) || (in_op == OP_MSUB);
        ext_a      = mul_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
        ext_b      = mul_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
        mul_prod   = ext_a * ext_b;
    end

    // ---------------- divide operand prep and one radix-2^DIV_BITS step ----------------
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    always_comb begin
        a_neg = (in_op == OP_DIV) && in_a[WIDTH-1];
        b_neg = (in_op == OP_DIV) && in_b[WIDTH-1];
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;
    end

    // NOTE: blocking assignments here are deliberate -- each sub-step must see the previous
    // one within the same cycle; clocked state below uses non-blocking only.
    always_comb begin
        rem_step = {1'b0, rem_q};
        quo_step = quo_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            rem_step = {rem_step[WIDTH-1:0], quo_step[WIDTH-1]};
            quo_step = {quo_step[WIDTH-2:0], 1'b0};
            if (rem_step >= {1'b0, dvs_q}) begin
                rem_step    = rem_step - {1'b0, dvs_q};
                quo_step[0] = 1'b1;
            end
        end
    end

    // ---------------- mul/div FSM next state ----------------
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_d    = prod_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        unique case (state_q)
            ST_IDLE: begin
                if (issue && is_mul) begin
                    prod_d  = mul_prod;
                    kind_d  = (in_op == OP_MSUB) ? K_MSUB :
                              ((in_op == OP_MADD) || (in_op == OP_MADDU)) ? K_MADD : K_MUL;
                    cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    // The accept cycle is the first latency cycle; DONE lands MUL_LATENCY
                    // cycles after accept.
                    state_d = (MUL_LATENCY > 1) ? ST_MUL : ST_DONE;
                end else if (issue && is_div) begin
                    kind_d    = K_DIV;
                    quo_d     = a_mag;
                    rem_d     = '0;
                    dvs_d     = b_mag;
                    dvd_d     = in_a;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (in_b == '0);
                    cnt_d     = CNT_W'(WIDTH / DIV_BITS - 1);
                    state_d   = ST_DIV;
                end else if (issue && (in_op == OP_MTHI)) begin
                    hi_d = in_a;
                end else if (issue && (in_op == OP_MTLO)) begin
                    lo_d = in_a;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                quo_d = quo_step;
                rem_d = rem_step[WIDTH-1:0];
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Commits even under flush: the result is architecturally complete.
                state_d = ST_IDLE;
                case (kind_q)
                    K_MUL:  {hi_d, lo_d} = prod_q;
                    K_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                    K_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
                    default: begin
                        if (div0_q) begin
                            lo_d = '1;
                            hi_d = dvd_q;
                        end else begin
                            lo_d = neg_quo_q ? -quo_q : quo_q;
                            hi_d = neg_rem_q ? -rem_q : rem_q;
                        end
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all clocked state; datapath registers are reset too
    // so HI/LO and the divider never expose stale values after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= K_MUL;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            prod_q    <= prod_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    // ---------------- EX/MEM outputs ----------------
    logic             out_valid_d, out_illegal_d;
    logic [WIDTH-1:0] out_result_d, out_pc_d;
    logic [4:0]       out_dest_d;

    always_comb begin
        out_valid_d   = issue;
        out_illegal_d = in_valid && !flush && !legal;
        out_pc_d      = in_pc;
        out_dest_d    = '0;
        out_result_d  = '0;
        if (issue) begin
            if (is_alu) begin
                out_result_d = alu_res;
                out_dest_d   = in_dest;
            end else if (in_op == OP_MFHI) begin
                out_result_d = hi_q;
                out_dest_d   = in_dest;
            end else if (in_op == OP_MFLO) begin
                out_result_d = lo_q;
                out_dest_d   = in_dest;
            end
        end
    end

    if (DELAYED != 0) begin : g_registered
        logic             out_valid_q, out_illegal_q;
        logic [WIDTH-1:0] out_result_q, out_pc_q;
        logic [4:0]       out_dest_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q   <= 1'b0;
                out_illegal_q <= 1'b0;
                out_result_q  <= '0;
                out_pc_q      <= '0;
                out_dest_q    <= '0;
            end else begin
                out_valid_q   <= out_valid_d;
                out_illegal_q <= out_illegal_d;
                out_result_q  <= out_result_d;
                out_pc_q      <= out_pc_d;
                out_dest_q    <= out_dest_d;
            end
        end

        assign out_valid   = out_valid_q;
        assign out_illegal = out_illegal_q;
        assign out_result  = out_result_q;
        assign out_pc      = out_pc_q;
        assign out_dest    = out_dest_q;
    end else begin : g_combinational
        assign out_valid   = out_valid_d;
        assign out_illegal = out_illegal_d;
        assign out_result  = out_result_d;
        assign out_pc      = out_pc_d;
        assign out_dest    = out_dest_d;
    end

endmodule

// File: tb/tb_mips_stage_ex_muldiv.sv
// Directed self-checking bench for mips_stage_ex_muldiv (WIDTH=32, DELAYED=1, MUL_LATENCY=4, DIV_BITS=2).
module tb_mips_stage_ex_muldiv;
    import mips_ex_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    Data_Control_Control_T ctrl;
    assign ctrl = '{clock: clk, reset: rst_n};

    logic        in_valid, flush;
    logic [4:0]  in_op, in_shamt, in_dest;
    logic [31:0] in_a, in_b, in_pc;
    logic        stall, out_valid, out_illegal, busy;
    logic [31:0] out_result, out_pc;
    logic [4:0]  out_dest;

    int total = 0;
    int bad   = 0;
    int n_stall;

    mips_stage_ex_muldiv #(.WIDTH(32), .DELAYED(1), .MUL_LATENCY(4), .DIV_BITS(2)) dut (
        .ctrl(ctrl), .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_shamt(in_shamt), .in_dest(in_dest), .in_pc(in_pc), .flush(flush),
        .stall(stall), .out_valid(out_valid), .out_result(out_result), .out_dest(out_dest),
        .out_pc(out_pc), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in_valid = 1'b0; in_op = 5'd0; in_a = '0; in_b = '0;
        in_shamt = 5'd0; in_dest = 5'd0; flush = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic [4:0] shamt);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dest = dest; in_shamt = shamt;
        flush = 1'b0;
    endtask

    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] shamt, input logic [31:0] exp);
        drive(op, a, b, 5'd3, shamt);
        #1;
        check({tag, "_stall"}, stall, 1'b0);
        tick();
        quiet();
        check(tag, out_result, exp);
    endtask

    task automatic issue_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        drive(op, a, b, 5'd9, 5'd0);
        #1;
        check({tag, "_stall"}, stall, 1'b0);
        tick();
        quiet();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_dest"}, out_dest, 5'd0);
    endtask

    task automatic read_hilo(input string tag, input logic [4:0] op, input logic [31:0] exp,
                             output int stalls);
        drive(op, 32'h0, 32'h0, 5'd7, 5'd0);
        #1;
        stalls = 0;
        while (stall && stalls < 100) begin
            stalls++;
            tick();
        end
        check({tag, "_bounded"}, (stalls < 100), 1'b1);
        tick();
        quiet();
        check(tag, out_result, exp);
        check({tag, "_dest"}, out_dest, 5'd7);
    endtask

    initial begin
        quiet();
        in_pc = 32'h0;

        // Reset state
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_result", out_result, 32'h0);
        check("rst_dest", out_dest, 5'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_illegal", out_illegal, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ALU: wrap, sign handling, shifts, LUI
        in_pc = 32'h0000_1000;
        alu("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000);
        check("add_valid", out_valid, 1'b1);
        check("add_dest", out_dest, 5'd3);
        check("add_pc", out_pc, 32'h0000_1000);
        alu("sub_wrap", OP_SUB, 32'h0, 32'h1, 5'd0, 32'hFFFF_FFFF);
        alu("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1);
        alu("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
        alu("sra", OP_SRA, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000);
        alu("srl", OP_SRL, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000);
        alu("sll31", OP_SLL, 32'h0, 32'h1, 5'd31, 32'h8000_0000);
        alu("lui", OP_LUI, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000);
        alu("nor", OP_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF);
        alu("xor", OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFF00_0FF0);

        // MTLO then MFLO
        issue_md("mtlo", OP_MTLO, 32'h55, 32'h0);
        read_hilo("mflo_mt", OP_MFLO, 32'h55, n_stall);
        check("mflo_mt_nostall", n_stall, 0);

        // MULT -3 x 5, dependent MFLO stalls MUL_LATENCY cycles
        issue_md("mult", OP_MULT, 32'hFFFF_FFFD, 32'h5);
        check("mult_busy", busy, 1'b1);
        read_hilo("mult_lo", OP_MFLO, 32'hFFFF_FFF1, n_stall);
        check("mult_stalls", n_stall, 4);
        read_hilo("mult_hi", OP_MFHI, 32'hFFFF_FFFF, n_stall);

        // MULTU all ones squared
        issue_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_hilo("multu_hi", OP_MFHI, 32'hFFFF_FFFE, n_stall);
        read_hilo("multu_lo", OP_MFLO, 32'h0000_0001, n_stall);

        // DIV -7/2 with an ALU op flowing past the busy unit
        issue_md("div", OP_DIV, 32'hFFFF_FFF9, 32'h2);
        alu("add_busy", OP_ADD, 32'h2, 32'h3, 5'd0, 32'h5);
        read_hilo("div_lo", OP_MFLO, 32'hFFFF_FFFD, n_stall);
        check("div_stalls", n_stall, 16);
        read_hilo("div_hi", OP_MFHI, 32'hFFFF_FFFF, n_stall);

        // Divide by zero and the overflow case
        issue_md("divu0", OP_DIVU, 32'h7, 32'h0);
        read_hilo("divu0_lo", OP_MFLO, 32'hFFFF_FFFF, n_stall);
        read_hilo("divu0_hi", OP_MFHI, 32'h7, n_stall);
        issue_md("divmin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo("divmin_lo", OP_MFLO, 32'h8000_0000, n_stall);
        read_hilo("divmin_hi", OP_MFHI, 32'h0, n_stall);

        // Flush mid-MULT (together with a dependent op): flush wins, HI/LO keep old values
        issue_md("mthi", OP_MTHI, 32'h11, 32'h0);
        issue_md("mtlo2", OP_MTLO, 32'h22, 32'h0);
        issue_md("mult_fl", OP_MULT, 32'h3, 32'h3);
        tick();
        drive(OP_MFLO, 32'h0, 32'h0, 5'd7, 5'd0);
        flush = 1'b1;
        #1;
        check("flush_stall", stall, 1'b0);
        tick();
        quiet();
        check("flush_valid", out_valid, 1'b0);
        check("flush_busy", busy, 1'b0);
        read_hilo("flush_hi", OP_MFHI, 32'h11, n_stall);
        check("flush_hi_nostall", n_stall, 0);
        read_hilo("flush_lo", OP_MFLO, 32'h22, n_stall);

        // Flushed ALU op produces no EX/MEM entry
        drive(OP_ADD, 32'h1, 32'h1, 5'd3, 5'd0);
        flush = 1'b1;
        tick();
        quiet();
        check("flush_alu_valid", out_valid, 1'b0);

        // Op beyond the table is illegal in every build
        drive(5'd23, 32'h5, 32'h5, 5'd3, 5'd0);
        #1;
        check("ill23_stall", stall, 1'b0);
        tick();
        quiet();
        check("ill23_illegal", out_illegal, 1'b1);
        check("ill23_valid", out_valid, 1'b0);
        tick();
        check("ill23_one_cycle", out_illegal, 1'b0);

`ifdef MIPS_EX_MADD_EN
        issue_md("mthi1", OP_MTHI, 32'h1, 32'h0);
        issue_md("mtlo1", OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        issue_md("madd", OP_MADD, 32'h1, 32'h1);
        read_hilo("madd_hi", OP_MFHI, 32'h2, n_stall);
        read_hilo("madd_lo", OP_MFLO, 32'h0, n_stall);
`else
        drive(OP_MADD, 32'h1, 32'h1, 5'd3, 5'd0);
        tick();
        quiet();
        check("madd_illegal", out_illegal, 1'b1);
        check("madd_valid", out_valid, 1'b0);
        check("madd_busy", busy, 1'b0);
        tick();
        check("madd_one_cycle", out_illegal, 1'b0);
        read_hilo("madd_hi_keep", OP_MFHI, 32'h11, n_stall);
        read_hilo("madd_lo_keep", OP_MFLO, 32'h22, n_stall);
`endif

        // Reset asserted mid-DIV
        issue_md("div_rst", OP_DIV, 32'd100, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("rstmid_busy_after", busy, 1'b0);
        read_hilo("rstmid_lo", OP_MFLO, 32'h0, n_stall);
        check("rstmid_nostall", n_stall, 0);
        read_hilo("rstmid_hi", OP_MFHI, 32'h0, n_stall);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
